morse_keyer: RTL and testbench

//  Buffers 7-bit ASCII characters and keys them out as timed Morse on/off signal.

---
 rtl/morse_pkg.sv | 38 +++
 rtl/morse_lut.sv | 70 +++++++
 rtl/morse_keyer.sv | 179 +++++++++++++++++
 tb/tb_morse_keyer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types, ASCII constants and default timing for the Morse keyer.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  // LUT entry: little-endian element code (bit0 keyed first, 1 = dash) and element count.
  localparam int CODE_W = 7;
  localparam int LEN_W  = 3;
  localparam int LUT_W  = CODE_W + LEN_W;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
  } lut_entry_t;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_LA    = 7'h61;
  localparam logic [6:0] ASCII_LZ    = 7'h7A;

  localparam int DEF_UNIT_CYCLES    = 2400000;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_DASH_UNITS     = 3;
  localparam int DEF_CHAR_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS = 7;

  // Lowercase letters share the uppercase codes.
  function automatic logic [6:0] fold_case(input logic [6:0] c);
    if (c >= ASCII_LA && c <= ASCII_LZ) return c - 7'h20;
    return c;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII -> {code,len} ROM. Unsupported characters (including space) return all zeros.
module morse_lut
  import morse_pkg::*;
(
  input  logic [6:0] ascii,
  output lut_entry_t entry
);

  function automatic lut_entry_t mk(input int unsigned c, input int unsigned l);
    lut_entry_t e;
    e.code = CODE_W'(c);
    e.len  = LEN_W'(l);
    return e;
  endfunction

  logic [6:0] ch;

  // Case-folded character lookup.
  always_comb begin
    ch    = fold_case(ascii);
    entry = '0;
    case (ch)
      7'h41: entry = mk(2, 2);    // A .-
      7'h42: entry = mk(1, 4);    // B -...
      7'h43: entry = mk(5, 4);    // C -.-.
      7'h44: entry = mk(1, 3);    // D -..
      7'h45: entry = mk(0, 1);    // E .
      7'h46: entry = mk(4, 4);    // F ..-.
      7'h47: entry = mk(3, 3);    // G --.
      7'h48: entry = mk(0, 4);    // H ....
      7'h49: entry = mk(0, 2);    // I ..
      7'h4A: entry = mk(14, 4);   // J .---
      7'h4B: entry = mk(5, 3);    // K -.-
      7'h4C: entry = mk(2, 4);    // L .-..
      7'h4D: entry = mk(3, 2);    // M --
      7'h4E: entry = mk(1, 2);    // N -.
      7'h4F: entry = mk(7, 3);    // O ---
      7'h50: entry = mk(6, 4);    // P .--.
      7'h51: entry = mk(11, 4);   // Q --.-
      7'h52: entry = mk(2, 3);    // R .-.
      7'h53: entry = mk(0, 3);    // S ...
      7'h54: entry = mk(1, 1);    // T -
      7'h55: entry = mk(4, 3);    // U ..-
      7'h56: entry = mk(8, 4);    // V ...-
      7'h57: entry = mk(6, 3);    // W .--
      7'h58: entry = mk(9, 4);    // X -..-
      7'h59: entry = mk(13, 4);   // Y -.--
      7'h5A: entry = mk(3, 4);    // Z --..
      7'h30: entry = mk(31, 5);   // 0 -----
      7'h31: entry = mk(30, 5);   // 1 .----
      7'h32: entry = mk(28, 5);   // 2 ..---
      7'h33: entry = mk(24, 5);   // 3 ...--
      7'h34: entry = mk(16, 5);   // 4 ....-
      7'h35: entry = mk(0, 5);    // 5 .....
      7'h36: entry = mk(1, 5);    // 6 -....
      7'h37: entry = mk(3, 5);    // 7 --...
      7'h38: entry = mk(7, 5);    // 8 ---..
      7'h39: entry = mk(15, 5);   // 9 ----.
      7'h2E: entry = mk(42, 6);   // . .-.-.-
      7'h2C: entry = mk(51, 6);   // , --..--
      7'h3F: entry = mk(12, 6);   // ? ..--..
      7'h2F: entry = mk(9, 5);    // / -..-.
      7'h3D: entry = mk(17, 5);   // = -...-
      7'h2D: entry = mk(33, 6);   // - -....-
      7'h2B: entry = mk(10, 5);   // + .-.-.
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Buffers ASCII characters in a small FIFO and keys them out as ITU-timed Morse.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = DEF_UNIT_CYCLES,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int DASH_UNITS     = DEF_DASH_UNITS,
  parameter int CHAR_GAP_UNITS = DEF_CHAR_GAP_UNITS,
  parameter int WORD_GAP_UNITS = DEF_WORD_GAP_UNITS
) (
  input  logic                          clk_24,
  input  logic                          rst,
  input  logic                          ascii_valid,
  output logic                          ascii_ready,
  input  logic [6:0]                    ascii_code,
  input  logic                          abort,
  output logic                          key_out,
  output logic                          busy,
  output logic                          unsupported,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int WGAP_UNITS = WORD_GAP_UNITS - CHAR_GAP_UNITS;
  // Longest single timed interval, so the one shared timer covers every state.
  localparam int MAX_UNITS0 = (DASH_UNITS > CHAR_GAP_UNITS) ? DASH_UNITS : CHAR_GAP_UNITS;
  localparam int MAX_UNITS  = (MAX_UNITS0 > WGAP_UNITS) ? MAX_UNITS0 : WGAP_UNITS;
  localparam int TIMER_W    = $clog2(MAX_UNITS * UNIT_CYCLES) + 1;

  // Reload values are interval-1: the state is left on the edge after the timer reads zero.
  localparam logic [TIMER_W-1:0] T_DOT  = TIMER_W'(UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_DASH = TIMER_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_CHAR = TIMER_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_WORD = TIMER_W'(WGAP_UNITS * UNIT_CYCLES - 1);

  logic [6:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               rdy_en;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [CODE_W-1:0]  shreg;
  logic [LEN_W-1:0]   elems;
  logic               key_r, unsup_r;

  logic               full, empty, push, pop, expired, dispatch, is_space;
  logic [6:0]         head;
  lut_entry_t         ent;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign ascii_ready = rdy_en & ~full & ~abort;
  assign push        = ascii_valid & ascii_ready;
  assign expired     = (timer == '0);
  // A gap that expires dispatches the next character directly, so marks follow gaps with no idle cycle.
  assign dispatch    = (state == IDLE) | (((state == CHAR_GAP) | (state == WORD_GAP)) & expired);
  assign pop         = dispatch & ~empty & ~abort;
  assign head        = mem[rd_ptr];
  assign is_space    = (head == ASCII_SPACE);

  assign key_out     = key_r;
  assign unsupported = unsup_r;
  assign fifo_count  = count;
  assign busy        = (state != IDLE) | ~empty;

  morse_lut u_lut (
    .ascii (head),
    .entry (ent)
  );

  // Hold ready low until the first edge after reset release.
  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge clk_24) begin
    if (push) mem[wr_ptr] <= ascii_code;
  end

  // FIFO pointers and occupancy; abort flushes everything.
  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Keying FSM with the shared down-counter and registered outputs.
  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      shreg   <= '0;
      elems   <= '0;
      key_r   <= 1'b0;
      unsup_r <= 1'b0;
    end else begin
      unsup_r <= 1'b0;
      if (abort) begin
        state <= IDLE;
        timer <= '0;
        shreg <= '0;
        elems <= '0;
        key_r <= 1'b0;
      end else if (dispatch) begin
        if (pop) begin
          if (is_space) begin
            state <= WORD_GAP;
            timer <= T_WORD;
            key_r <= 1'b0;
          end else if (ent.len == '0) begin
            unsup_r <= 1'b1;
            state   <= IDLE;
            timer   <= '0;
            key_r   <= 1'b0;
          end else begin
            shreg <= ent.code;
            elems <= ent.len - LEN_W'(1);
            timer <= ent.code[0] ? T_DASH : T_DOT;
            key_r <= 1'b1;
            state <= MARK;
          end
        end else begin
          state <= IDLE;
          timer <= '0;
          key_r <= 1'b0;
        end
      end else begin
        case (state)
          MARK: begin
            if (expired) begin
              key_r <= 1'b0;
              if (elems != '0) begin
                state <= ELEM_GAP;
                timer <= T_DOT;
              end else begin
                state <= CHAR_GAP;
                timer <= T_CHAR;
              end
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          ELEM_GAP: begin
            if (expired) begin
              shreg <= shreg >> 1;
              elems <= elems - LEN_W'(1);
              timer <= shreg[1] ? T_DASH : T_DOT;
              key_r <= 1'b1;
              state <= MARK;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          CHAR_GAP, WORD_GAP: timer <= timer - TIMER_W'(1);
          default:            state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Randomized and directed bench for morse_keyer against a dot/dash-string reference model.
module tb_morse_keyer;

  localparam int U  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk_24 = 1'b0;
  logic          rst = 1'b1;
  logic          ascii_valid = 1'b0;
  logic [6:0]    ascii_code = '0;
  logic          abort = 1'b0;
  logic          ascii_ready, key_out, busy, unsupported;
  logic [CW-1:0] fifo_count;

  int tests = 0;
  int fails = 0;

  typedef byte bq_t[$];

  morse_keyer #(.UNIT_CYCLES(U), .FIFO_DEPTH(D)) dut (
    .clk_24      (clk_24),
    .rst         (rst),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .ascii_code  (ascii_code),
    .abort       (abort),
    .key_out     (key_out),
    .busy        (busy),
    .unsupported (unsupported),
    .fifo_count  (fifo_count)
  );

  always #5 clk_24 = ~clk_24;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ITU Morse as dot/dash text; "" means no code.
  function automatic string pat(input byte c);
    byte u;
    u = c;
    if (u >= "a" && u <= "z") u = byte'(u - 8'd32);
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      ".": return ".-.-.-"; ",": return "--..--"; "?": return "..--..";
      "/": return "-..-.";  "=": return "-...-";  "-": return "-....-"; "+": return ".-.-.";
      default: return "";
    endcase
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Streams seq with valid held whenever data remains; checks every key_out cycle against the model.
  task automatic run_seq(input string tag, input bq_t seq, output int maxc);
    bit    expq[$];
    int    nunsup, idx, k, seen, guard;
    bit    started, acc, e;
    string p;
    nunsup = 0;
    foreach (seq[i]) begin
      if (seq[i] == 8'h20) begin
        repeat (U * (7 - 3)) expq.push_back(1'b0);
      end else begin
        p = pat(seq[i]);
        if (p.len() == 0) begin
          expq.push_back(1'b0);
          nunsup++;
        end else begin
          for (int j = 0; j < p.len(); j++) begin
            repeat ((p[j] == "-") ? 3 * U : U) expq.push_back(1'b1);
            if (j < p.len() - 1) repeat (U) expq.push_back(1'b0);
          end
          repeat (3 * U) expq.push_back(1'b0);
        end
      end
    end
    idx = 0; k = -1; seen = 0; guard = 0; maxc = 0; started = 1'b0;
    while (!(started && idx == seq.size() && k >= expq.size() + 2)) begin
      @(negedge clk_24);
      if (started) begin
        if (k >= 0) begin
          e = (k < expq.size()) ? expq[k] : 1'b0;
          chk($sformatf("%s key[%0d]", tag, k), key_out, e);
        end else begin
          chk($sformatf("%s key_pre", tag), key_out, 1'b0);
        end
        k++;
      end
      chk($sformatf("%s ready", tag), ascii_ready, (fifo_count < D));
      if (unsupported) seen++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (idx < seq.size()) begin
        ascii_valid = 1'b1;
        ascii_code  = seq[idx][6:0];
      end else begin
        ascii_valid = 1'b0;
      end
      acc = ascii_valid & ascii_ready;
      @(posedge clk_24);
      if (acc) begin
        idx++;
        started = 1'b1;
      end
      guard++;
      if (guard > 20000) begin
        chk($sformatf("%s timeout", tag), guard, 0);
        break;
      end
    end
    ascii_valid = 1'b0;
    #1;
    chk($sformatf("%s busy_end", tag), busy, 1'b0);
    chk($sformatf("%s count_end", tag), fifo_count, 0);
    chk($sformatf("%s unsup_cycles", tag), seen, nunsup);
  endtask

  initial begin
    int    maxc, highs;
    bq_t   q;
    string pool;
    pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789 .,?/=-+#!@*~";

    // Reset state
    #12;
    chk("rst key_out", key_out, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst unsupported", unsupported, 1'b0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst ready", ascii_ready, 1'b0);
    @(negedge clk_24);
    rst = 1'b0;
    #1;
    chk("ready before first edge", ascii_ready, 1'b0);
    @(posedge clk_24);
    #1;
    chk("ready after first edge", ascii_ready, 1'b1);

    // Directed patterns
    run_seq("E", str2q("E"), maxc);
    run_seq("a", str2q("a"), maxc);
    run_seq("A", str2q("A"), maxc);
    run_seq("E_E", str2q("E E"), maxc);
    run_seq("hash_T", str2q("#T"), maxc);
    run_seq("S6", str2q("SSSSSS"), maxc);
    chk("S6 max fifo_count", maxc, D);
    run_seq("digits", str2q("0189"), maxc);
    run_seq("punct", str2q(".,?/=-+"), maxc);
    run_seq("spaces_unsup", str2q("  !@x"), maxc);

    // Random strings
    for (int r = 0; r < 8; r++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(3, 8)); i++)
        q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
      run_seq($sformatf("rand%0d", r), q, maxc);
    end

    // Abort mid-dash of 'O' with two characters queued
    @(negedge clk_24); ascii_valid = 1'b1; ascii_code = 7'h4F;
    @(posedge clk_24);
    @(negedge clk_24); ascii_code = 7'h45;
    @(posedge clk_24);
    @(negedge clk_24); ascii_code = 7'h54;
    @(posedge clk_24);
    @(negedge clk_24); ascii_valid = 1'b0;
    repeat (4) @(negedge clk_24);
    chk("abort pre key_out", key_out, 1'b1);
    chk("abort pre fifo_count", fifo_count, 2);
    abort = 1'b1;
    #1;
    chk("abort ready", ascii_ready, 1'b0);
    @(posedge clk_24);
    #1;
    chk("abort key_out", key_out, 1'b0);
    chk("abort fifo_count", fifo_count, 0);
    chk("abort busy", busy, 1'b0);
    @(negedge clk_24);
    abort = 1'b0;
    highs = 0;
    repeat (40) begin
      @(negedge clk_24);
      if (key_out) highs++;
    end
    chk("abort no resume", highs, 0);
    chk("abort busy later", busy, 1'b0);

    // Reset mid-mark of 'T'
    @(negedge clk_24); ascii_valid = 1'b1; ascii_code = 7'h54;
    @(posedge clk_24);
    @(negedge clk_24); ascii_valid = 1'b0;
    repeat (3) @(negedge clk_24);
    chk("rst-mid pre key_out", key_out, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst-mid key_out", key_out, 1'b0);
    chk("rst-mid busy", busy, 1'b0);
    chk("rst-mid fifo_count", fifo_count, 0);
    @(negedge clk_24);
    rst = 1'b0;
    @(posedge clk_24);
    #1;
    chk("rst-mid ready", ascii_ready, 1'b1);
    run_seq("E_after_rst", str2q("E"), maxc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
